// File: rtl/spi_master_if.sv
// Handshake and serial-pin bundle for spi_master.
// The master modport is the block's own view; slave is the view of the logic driving it.
interface spi_master_if #(
  parameter int unsigned DW = 8
) ();
  logic          tx_vld;
  logic          tx_rdy;
  logic [DW-1:0] tx_dat;
  logic [DW-1:0] rx_dat;
  logic          rx_vld;
  logic          busy;
  logic          cs_n;
  logic          sclk;
  logic          sdo;
  logic          sdi;

  modport master (
    input  tx_vld, tx_dat, sdi,
    output tx_rdy, rx_dat, rx_vld, busy, cs_n, sclk, sdo
  );

  modport slave (
    output tx_vld, tx_dat, sdi,
    input  tx_rdy, rx_dat, rx_vld, busy, cs_n, sclk, sdo
  );
endinterface

// File: rtl/spi_master.sv
// Full-duplex SPI master with configurable width, SCLK divider, CPOL/CPHA and bit order.
// One frame per accepted word; the received word is returned with a one-cycle strobe.
module spi_master #(
  parameter int unsigned DW        = 8,
  parameter int unsigned DIV       = 2,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  localparam int unsigned CW = $clog2(2 * DW + 1);
  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LastTog = CW'(2 * DW - 1);
  localparam logic [TW-1:0] TickVal = TW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StLead, StXfer, StTrail} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] tog_q, tog_d;
  logic          sclk_q, sclk_d;
  logic          sdo_q, sdo_d;
  logic [DW-1:0] tx_sh_q, tx_sh_d;
  logic [DW-1:0] rx_sh_q, rx_sh_d;
  logic [DW-1:0] rx_dat_q, rx_dat_d;
  logic          rx_vld_q, rx_vld_d;

  logic tx_rdy;
  logic accept, tick, toggle, leading, last_tog, do_sample, do_shift;

  function automatic logic [DW-1:0] shift_next(logic [DW-1:0] x);
    if (MSB_FIRST) return {x[DW-2:0], 1'b0};
    else           return {1'b0, x[DW-1:1]};
  endfunction

  function automatic logic out_bit(logic [DW-1:0] x);
    if (MSB_FIRST) return x[DW-1];
    else           return x[0];
  endfunction

  function automatic logic [DW-1:0] rx_insert(logic [DW-1:0] x, logic b);
    if (MSB_FIRST) return {x[DW-2:0], b};
    else           return {b, x[DW-1:1]};
  endfunction

  assign accept   = bus.tx_vld & tx_rdy;
  assign tick     = (tmr_q == TickVal);
  assign toggle   = (state_q == StXfer) & tick;
  // tog_q counts completed toggles, so an even count means the next toggle is a leading edge.
  assign leading  = ~tog_q[0];
  assign last_tog = (tog_q == LastTog);
  assign do_sample = toggle & (CPHA ? ~leading : leading);
  assign do_shift  = toggle & (CPHA ? leading : (~leading & ~last_tog));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept)             state_d = StLead;
      StLead:  if (tick)               state_d = StXfer;
      StXfer:  if (tick && last_tog)   state_d = StTrail;
      StTrail: if (tick)               state_d = StIdle;
      default:                         state_d = StIdle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    tx_rdy   = 1'b0;
    bus.busy = 1'b0;
    bus.cs_n = 1'b1;
    case (state_q)
      StIdle: begin
        tx_rdy = 1'b1;
      end
      StLead, StXfer, StTrail: begin
        bus.busy = 1'b1;
        bus.cs_n = 1'b0;
      end
      default: begin
        tx_rdy = 1'b1;
      end
    endcase
  end

  assign bus.tx_rdy = tx_rdy;
  assign bus.sclk   = sclk_q;
  assign bus.sdo    = sdo_q;
  assign bus.rx_dat = rx_dat_q;
  assign bus.rx_vld = rx_vld_q;

  // Datapath next-state: timer, toggle counter, shifters and result capture.
  always_comb begin
    tmr_d    = tmr_q;
    tog_d    = tog_q;
    sclk_d   = sclk_q;
    sdo_d    = sdo_q;
    tx_sh_d  = tx_sh_q;
    rx_sh_d  = rx_sh_q;
    rx_dat_d = rx_dat_q;
    rx_vld_d = 1'b0;

    if (state_q == StIdle) begin
      tmr_d = '0;
    end else if (tick) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TW'(1);
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          tx_sh_d = bus.tx_dat;
          sdo_d   = out_bit(bus.tx_dat);
          rx_sh_d = '0;
          tog_d   = '0;
          sclk_d  = CPOL;
        end
      end
      StXfer: begin
        if (toggle) begin
          sclk_d = ~sclk_q;
          tog_d  = tog_q + CW'(1);
        end
        if (do_sample) begin
          rx_sh_d = rx_insert(rx_sh_q, bus.sdi);
        end
        if (do_shift) begin
          // CPHA=1 drives the current bit then advances; CPHA=0 advances then drives.
          if (CPHA) begin
            sdo_d   = out_bit(tx_sh_q);
            tx_sh_d = shift_next(tx_sh_q);
          end else begin
            tx_sh_d = shift_next(tx_sh_q);
            sdo_d   = out_bit(shift_next(tx_sh_q));
          end
        end
      end
      StTrail: begin
        if (tick) begin
          rx_dat_d = rx_sh_q;
          rx_vld_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q    <= '0;
      tog_q    <= '0;
      sclk_q   <= CPOL;
      sdo_q    <= 1'b0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      rx_dat_q <= '0;
      rx_vld_q <= 1'b0;
    end else begin
      tmr_q    <= tmr_d;
      tog_q    <= tog_d;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      rx_dat_q <= rx_dat_d;
      rx_vld_q <= rx_vld_d;
    end
  end

endmodule
